// File: rtl/moving_sum_filter.sv
// Boxcar filter: o_y is the registered sum of the last DEPTH samples, one sample per clk.
// Latency: a sample shows up in o_y right after its capturing edge; no handshake, never stalls.
module moving_sum_filter #(
   parameter  int DATA_W = 8,
   parameter  int DEPTH  = 8,
   localparam int SUM_W  = DATA_W + $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] i_data,
   output logic [SUM_W-1:0]  o_y
);

   logic [DATA_W-1:0] hist [DEPTH];
   logic [SUM_W-1:0]  acc_nxt;

   // The oldest sample is always part of o_y, so subtracting it first cannot
   // underflow, and the following add never exceeds DEPTH*(2^DATA_W-1).
   always_comb begin
      acc_nxt = (o_y - SUM_W'(hist[DEPTH-1])) + SUM_W'(i_data);
   end

   // rst_n is active-high despite its name.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            hist[i] <= '0;
         end
         o_y <= '0;
      end else begin
         hist[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) begin
            hist[i] <= hist[i-1];
         end
         o_y <= acc_nxt;
      end
   end

endmodule

// File: tb/tb_moving_sum_filter.sv
// Randomized and directed bench for moving_sum_filter, checked by a scoreboard
// fed from a sliding-window reference model.
module tb_moving_sum_filter;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int SUM_W  = DATA_W + $clog2(DEPTH);

   logic              clk;
   logic              rst_n;
   logic [DATA_W-1:0] i_data;
   logic [SUM_W-1:0]  o_y;

   int total = 0;
   int bad   = 0;

   int    win [$];     // captured samples since reset, newest first
   int    exp_q [$];   // expected o_y after each upcoming edge
   string tag_q [$];

   moving_sum_filter #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (i_data),
      .o_y    (o_y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: o_y=%0d expected=%0d at t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int win_sum();
      int s = 0;
      foreach (win[i]) s += win[i];
      return s;
   endfunction

   // Drive one edge's worth of stimulus away from posedge and predict the result.
   task automatic step(input logic r, input int d, input string nm);
      @(negedge clk);
      rst_n  = r;
      i_data = DATA_W'(d);
      if (r) begin
         win.delete();
      end else begin
         win.push_front(d);
         if (win.size() > DEPTH) void'(win.pop_back());
      end
      exp_q.push_back(win_sum());
      tag_q.push_back(nm);
   endtask

   // Assert reset between edges; o_y must clear without waiting for clk.
   task automatic mid_reset(input string nm);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      win.delete();
      #1;
      check(nm, int'(o_y), 0);
   endtask

   // Monitor: compare every edge that has a pending expectation.
   initial begin
      int    e;
      string nm;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = tag_q.pop_front();
            check(nm, int'(o_y), e);
         end
      end
   end

   initial begin
      rst_n  = 1'b1;
      i_data = '0;
      #3;
      check("reset_state", int'(o_y), 0);

      // Reset held while data toggles.
      for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(255), "reset_hold");

      // Constant full-scale input: ramps to 2040 and holds.
      for (int i = 0; i < 12; i++) step(1'b0, 255, "constant");

      step(1'b1, 0, "reset_gap");
      step(1'b0, 1, "impulse");
      for (int i = 0; i < 10; i++) step(1'b0, 0, "impulse");

      step(1'b1, 0, "reset_gap");
      for (int i = 1; i <= 8; i++) step(1'b0, i, "ramp");
      for (int i = 0; i < 10; i++) step(1'b0, 0, "ramp_down");

      // Mid-run reset from a full window of 100s.
      step(1'b1, 0, "reset_gap");
      for (int i = 0; i < 10; i++) step(1'b0, 100, "fill_100");
      mid_reset("mid_async_reset");
      for (int i = 0; i < 2; i++) step(1'b1, $urandom_range(255), "mid_reset_hold");
      for (int i = 0; i < 10; i++) step(1'b0, 5, "after_reset_5");

      // Random samples with occasional resets, one of them asynchronous.
      for (int i = 0; i < 10000; i++) begin
         if (i == 5000) begin
            mid_reset("rand_async_reset");
            step(1'b1, $urandom_range(255), "rand_reset_hold");
         end else if ($urandom_range(1999) == 0) begin
            step(1'b1, $urandom_range(255), "rand_reset");
         end else begin
            step(1'b0, $urandom_range(255), "random");
         end
      end

      repeat (3) @(posedge clk);
      #2;
      check("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
